iob_eth_tx_stream: RTL and testbench

IOB_ETH_TX_STREAM -- requirements
Module: iob_eth_tx_stream

---
 rtl/iob_eth_tx_stream_pkg.sv | 27 ++
 rtl/iob_eth_tx_stream_if.sv | 23 ++
 rtl/iob_eth_tx_ram.sv | 36 +++
 rtl/iob_eth_tx_stream.sv | 146 ++++++++++++++
 tb/tb_iob_eth_tx_stream.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/iob_eth_tx_stream_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet TX byte streamer.
// Buffer geometry (lanes, word width, depth) and FSM encodings live here.
package iob_eth_tx_stream_pkg;

  localparam int unsigned NumLanes = 4;
  localparam int unsigned LaneW    = 8;
  localparam int unsigned WordW    = NumLanes * LaneW;
  localparam int unsigned LaneIdxW = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StStream = 2'd2,
    StDone   = 2'd3
  } tx_state_e;

  function automatic int unsigned buf_depth(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

  // Little-endian lane select: lane 0 is bits 7:0.
  function automatic logic [LaneW-1:0] lane_byte(input logic [WordW-1:0]    word,
                                                 input logic [LaneIdxW-1:0] lane);
    return word[lane*LaneW +: LaneW];
  endfunction

endpackage

// File: rtl/iob_eth_tx_stream_if.sv
// Byte stream towards the MAC transmitter: valid/ready handshake with a last marker.
interface iob_eth_tx_stream_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/iob_eth_tx_ram.sv
// Frame buffer: byte-write synchronous RAM, one write port, one read port, 1-cycle read.
module iob_eth_tx_ram
  import iob_eth_tx_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic                clk,
  input  logic                wr,
  input  logic [NumLanes-1:0] wstrb,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WordW-1:0]    wdata,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [WordW-1:0]    rdata
);

  localparam int unsigned Depth = buf_depth(ADDR_W);

  logic [WordW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumLanes; i++) begin
      if (wr && wstrb[i]) begin
        mem[waddr][i*LaneW +: LaneW] <= wdata[i*LaneW +: LaneW];
      end
    end
  end

  // Read-first; rdata only moves when rd is set, so a captured word is immune to later writes.
  always_ff @(posedge clk) begin
    if (rd) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iob_eth_tx_stream.sv
// Streams a frame from the TX buffer to the MAC one byte per handshake, prefetching
// the next word so sustained ready gives one byte per cycle across word boundaries.
module iob_eth_tx_stream
  import iob_eth_tx_stream_pkg::*;
#(
  parameter int unsigned BUF_ADDR_W = 9,
  parameter int unsigned LEN_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WordW-1:0]      in_data,
  input  logic [BUF_ADDR_W-1:0] in_addr,
  input  logic                  in_wr,
  input  logic [NumLanes-1:0]   in_wstrb,
  input  logic                  tx_start,
  input  logic [LEN_W-1:0]      tx_nbytes,
  output logic                  tx_busy,
  iob_eth_tx_stream_if.master   tx
);

  tx_state_e             state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx_q;
  logic [WordW-1:0]      hold_q;
  logic [LaneW-1:0]      data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;

  logic                  ram_rd;
  logic [BUF_ADDR_W-1:0] ram_raddr;
  logic [WordW-1:0]      ram_rdata;

  logic [LEN_W-1:0]      idx_next;
  logic [LEN_W-1:0]      last_idx;
  logic [LEN_W-1:0]      word_after_next;
  logic                  hs;
  logic                  at_last;
  logic                  next_new_word;

  assign idx_next        = idx_q + LEN_W'(1);
  assign last_idx        = len_q - LEN_W'(1);
  assign word_after_next = (idx_next >> 2) + LEN_W'(1);
  assign hs              = valid_q & tx.tx_ready;
  assign at_last         = (idx_q == last_idx);
  assign next_new_word   = (idx_next[1:0] == 2'd0);

  iob_eth_tx_ram #(
    .ADDR_W (BUF_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .wr    (in_wr),
    .wstrb (in_wstrb),
    .waddr (in_addr),
    .wdata (in_data),
    .rd    (ram_rd),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Read scheduling: word 0 on accept, word 1 while fetching, then word n+1 each time
  // the stream crosses into word n (the prefetched word is consumed from rdata).
  always_comb begin
    ram_rd    = 1'b0;
    ram_raddr = '0;
    unique case (state_q)
      StIdle: begin
        if (tx_start && (tx_nbytes != '0)) begin
          ram_rd = 1'b1;
        end
      end
      StFetch: begin
        ram_rd    = 1'b1;
        ram_raddr = BUF_ADDR_W'(1);
      end
      StStream: begin
        if (hs && !at_last && next_new_word) begin
          ram_rd    = 1'b1;
          ram_raddr = BUF_ADDR_W'(word_after_next);
        end
      end
      StDone: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tx_start && (tx_nbytes != '0)) begin
            len_q   <= tx_nbytes;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          hold_q  <= ram_rdata;
          data_q  <= lane_byte(ram_rdata, 2'd0);
          last_q  <= (len_q == LEN_W'(1));
          valid_q <= 1'b1;
          state_q <= StStream;
        end
        StStream: begin
          if (hs) begin
            if (at_last) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              idx_q  <= idx_next;
              last_q <= (idx_next == last_idx);
              if (next_new_word) begin
                hold_q <= ram_rdata;
                data_q <= lane_byte(ram_rdata, 2'd0);
              end else begin
                data_q <= lane_byte(hold_q, idx_next[1:0]);
              end
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_busy     = busy_q;
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;

endmodule

// File: tb/tb_iob_eth_tx_stream.sv
// Directed bench for iob_eth_tx_stream: frame streaming, stalls, strobes, ignored starts,
// prefetch isolation and mid-frame reset.
module tb_iob_eth_tx_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [8:0]  in_addr;
  logic        in_wr;
  logic [3:0]  in_wstrb;
  logic        tx_start;
  logic [10:0] tx_nbytes;
  logic        tx_busy;

  iob_eth_tx_stream_if tx_if ();

  always #5 clk = ~clk;

  iob_eth_tx_stream #(
    .BUF_ADDR_W (9),
    .LEN_W      (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_wr     (in_wr),
    .in_wstrb  (in_wstrb),
    .tx_start  (tx_start),
    .tx_nbytes (tx_nbytes),
    .tx_busy   (tx_busy),
    .tx        (tx_if)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] cap_data [16];
  logic       cap_last [16];
  int         cap_n, cyc, hold_err, bubbles;
  bit         done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    in_addr = a; in_data = d; in_wstrb = s; in_wr = 1'b1;
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic start_frame(input logic [10:0] n);
    tx_start = 1'b1; tx_nbytes = n;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Observes the stream at negedges starting on the first valid byte; optional pokes.
  task automatic collect(input int max_cyc, input bit toggle, input int start_poke,
                         input bit wr_poke);
    logic [7:0] pdata;
    logic       plast;
    bit         stalled;
    cap_n = 0; cyc = 0; hold_err = 0; bubbles = 0; done = 1'b0; stalled = 1'b0;
    pdata = '0; plast = 1'b0;
    while (!done && cyc < max_cyc) begin
      tx_if.tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      tx_start = (cyc == start_poke);
      if (cyc == start_poke) tx_nbytes = 11'd3;
      in_wr = 1'b0;
      if (wr_poke && cyc == 0) begin
        in_wr = 1'b1; in_addr = 9'd1; in_data = 32'h0; in_wstrb = 4'hf;
      end
      if (wr_poke && cyc == 1) begin
        in_wr = 1'b1; in_addr = 9'd2; in_data = 32'hDEADBEEF; in_wstrb = 4'hf;
      end
      if (tx_if.tx_valid) begin
        if (stalled && (tx_if.tx_data !== pdata || tx_if.tx_last !== plast)) hold_err++;
        if (tx_if.tx_ready) begin
          cap_data[cap_n] = tx_if.tx_data;
          cap_last[cap_n] = tx_if.tx_last;
          cap_n++;
          stalled = 1'b0;
          if (tx_if.tx_last) done = 1'b1;
        end else begin
          stalled = 1'b1; pdata = tx_if.tx_data; plast = tx_if.tx_last;
        end
      end else if (cap_n > 0) begin
        bubbles++;
      end
      @(negedge clk);
      cyc++;
    end
    tx_start = 1'b0; in_wr = 1'b0; tx_if.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_checks++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_if.tx_valid); end
    n_checks++; if (tx_if.tx_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", tx_if.tx_last); end
    n_checks++; if (tx_if.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx_if.tx_data); end
  endtask

  task automatic test_full_frame();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    tx_if.tx_ready = 1'b1;
    start_frame(11'd8);
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_on_start: got %b want 1", tx_busy); end
    n_checks++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_fetch: got %b want 0", tx_if.tx_valid); end
    @(negedge clk);
    n_checks++; if (tx_if.tx_valid !== 1'b1) begin n_fail++; $display("FAIL full_first_valid_latency: got %b want 1", tx_if.tx_valid); end
    collect(20, 1'b0, -1, 1'b0);
    n_checks++; if (cap_n !== 8 || cyc !== 8 || bubbles !== 0) begin n_fail++; $display("FAIL full_count: got n=%0d cyc=%0d bubbles=%0d want 8 8 0", cap_n, cyc, bubbles); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 7)) begin n_fail++; $display("FAIL full_byte%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], i == 7); end
    end
    n_checks++; if (tx_busy !== 1'b1 || tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_done_state: got busy=%b valid=%b want 1 0", tx_busy, tx_if.tx_valid); end
    @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_release: got %b want 0", tx_busy); end
  endtask

  task automatic test_short_frame();
    logic [7:0] exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start_frame(11'd5);
    @(negedge clk);
    collect(20, 1'b0, -1, 1'b0);
    n_checks++; if (cap_n !== 5 || cyc !== 5) begin n_fail++; $display("FAIL short_count: got n=%0d cyc=%0d want 5 5", cap_n, cyc); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 4)) begin n_fail++; $display("FAIL short_byte%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], i == 4); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_frame(11'd8);
    @(negedge clk);
    collect(40, 1'b1, -1, 1'b0);
    n_checks++; if (cap_n !== 8 || hold_err !== 0) begin n_fail++; $display("FAIL stall_hold: got n=%0d hold_err=%0d want 8 0", cap_n, hold_err); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 7)) begin n_fail++; $display("FAIL stall_byte%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], i == 7); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_strobe();
    logic [7:0] exp [4] = '{8'hDD, 8'h22, 8'hBB, 8'h44};
    write_word(9'd0, 32'hAABBCCDD, 4'b0101);
    start_frame(11'd4);
    @(negedge clk);
    collect(20, 1'b0, -1, 1'b0);
    n_checks++; if (cap_n !== 4) begin n_fail++; $display("FAIL strobe_count: got %0d want 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 3)) begin n_fail++; $display("FAIL strobe_byte%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], i == 3); end
    end
    repeat (2) @(negedge clk);
    write_word(9'd0, 32'h44332211, 4'hf);
  endtask

  task automatic test_ignored_start();
    start_frame(11'd0);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_busy: got %b want 0", tx_busy); end
    @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL zero_len_idle: got busy=%b valid=%b want 0 0", tx_busy, tx_if.tx_valid); end
    start_frame(11'd8);
    @(negedge clk);
    collect(20, 1'b0, 2, 1'b0);
    n_checks++; if (cap_n !== 8 || cap_data[7] !== 8'h88 || cap_last[7] !== 1'b1) begin n_fail++; $display("FAIL busy_start_frame: got n=%0d last_byte=%h want 8 88", cap_n, cap_data[7]); end
    tx_start = 1'b1; tx_nbytes = 11'd3;
    @(negedge clk);
    tx_start = 1'b0;
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL done_start_busy: got %b want 0", tx_busy); end
    repeat (2) @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got busy=%b valid=%b want 0 0", tx_busy, tx_if.tx_valid); end
  endtask

  task automatic test_prefetch();
    logic [7:0] exp [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};
    write_word(9'd2, 32'hCCBBAA99, 4'hf);
    start_frame(11'd12);
    @(negedge clk);
    collect(30, 1'b0, -1, 1'b1);
    n_checks++; if (cap_n !== 12 || cyc !== 12) begin n_fail++; $display("FAIL prefetch_count: got n=%0d cyc=%0d want 12 12", cap_n, cyc); end
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (cap_data[i] !== exp[i]) begin n_fail++; $display("FAIL prefetch_byte%0d: got %h want %h", i, cap_data[i], exp[i]); end
    end
    repeat (2) @(negedge clk);
    write_word(9'd1, 32'h88776655, 4'hf);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_frame(11'd8);
    repeat (4) @(negedge clk);
    n_checks++; if (tx_if.tx_data !== 8'h44 || tx_if.tx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_byte3: got %h/%b want 44/1", tx_if.tx_data, tx_if.tx_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (tx_if.tx_valid !== 1'b0 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got valid=%b busy=%b want 0 0", tx_if.tx_valid, tx_busy); end
    n_checks++; if (tx_if.tx_data !== 8'h00 || tx_if.tx_last !== 1'b0) begin n_fail++; $display("FAIL midrst_data: got %h/%b want 00/0", tx_if.tx_data, tx_if.tx_last); end
    start_frame(11'd8);
    @(negedge clk);
    collect(20, 1'b0, -1, 1'b0);
    n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL midrst_count: got %0d want 8", cap_n); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (cap_data[i] !== exp[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h want %h", i, cap_data[i], exp[i]); end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_wr = 1'b0; in_addr = '0; in_data = '0; in_wstrb = '0;
    tx_start = 1'b0; tx_nbytes = '0; tx_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    write_word(9'd0, 32'h44332211, 4'hf);
    write_word(9'd1, 32'h88776655, 4'hf);
    test_full_frame();
    test_short_frame();
    test_stall();
    test_strobe();
    test_ignored_start();
    test_prefetch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
